// File: rtl/usb_ep_array_pkg.sv
// usb_pkg: handshake codes and control/status word bit positions shared by
// the endpoint array, its per-direction slices and the bus interface.
package usb_pkg;

    // Handshake codes presented to the protocol engine
    localparam logic [1:0] hs_ack   = 2'd0;
    localparam logic [1:0] hs_none  = 2'd1;
    localparam logic [1:0] hs_nak   = 2'd2;
    localparam logic [1:0] hs_stall = 2'd3;

    // Control word bits (bits [LEN_W-1:0] carry the IN byte count)
    localparam int CTRL_COMMIT     = 8;
    localparam int CTRL_SET_STALL  = 9;
    localparam int CTRL_CLR_STALL  = 10;
    localparam int CTRL_RST_TOGGLE = 11;
    localparam int CTRL_CANCEL     = 12;
    localparam int CTRL_CLR_DONE   = 13;
    localparam int CTRL_IRQ_EN     = 14;

    // Status word bits (bits [LEN_W-1:0] carry len[cpu_ptr])
    localparam int STAT_VALID_CUR = 8;
    localparam int STAT_VALID_OTH = 9;
    localparam int STAT_STALL     = 10;
    localparam int STAT_TOGGLE    = 11;
    localparam int STAT_CPU_PTR   = 12;
    localparam int STAT_WAS_SETUP = 13;
    localparam int STAT_DONE      = 15;

endpackage

// File: rtl/usb_ep_array_if.sv
// Bus bundle between the endpoint array (slave) and the USB protocol engine
// plus CPU IO bus (master).
interface usb_ep_array_if #(parameter int LEN_W = 7) ();
    // USB protocol engine side
    logic [3:0]       endpoint;
    logic             direction_in;
    logic             setup;
    logic             success;
    logic [LEN_W-1:0] cnt;
    logic             toggle;
    logic [1:0]       handshake;
    logic             bank;
    logic             in_data_valid;
    // CPU IO side
    logic [3:0]       ctrl_ep;
    logic             ctrl_dir_in;
    logic             ctrl_wr_strobe;
    logic [15:0]      ctrl_wr_data;
    logic [15:0]      ctrl_rd_data;
    logic             irq;

    modport master (
        output endpoint, direction_in, setup, success, cnt,
        output ctrl_ep, ctrl_dir_in, ctrl_wr_strobe, ctrl_wr_data,
        input  toggle, handshake, bank, in_data_valid, ctrl_rd_data, irq
    );

    modport slave (
        input  endpoint, direction_in, setup, success, cnt,
        input  ctrl_ep, ctrl_dir_in, ctrl_wr_strobe, ctrl_wr_data,
        output toggle, handshake, bank, in_data_valid, ctrl_rd_data, irq
    );
endinterface

// File: rtl/usb_ep_dir.sv
// usb_ep_dir: state of one direction of one endpoint -- two buffer banks,
// USB/CPU bank pointers, data toggle, stall, sticky done, SETUP marker.
// Optional macro USB_EP_IRQ_MASK_EN adds a per-direction interrupt enable.
module usb_ep_dir
    import usb_pkg::*;
#(
    parameter bit IS_IN = 1'b0,
    parameter int LEN_W = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_usb_hit,    // success addressed here
    input  logic                  i_setup,
    input  logic                  i_setup_hit,  // SETUP success on this endpoint
    input  logic [LEN_W-1:0]      i_cnt,
    input  logic                  i_ctrl_wr,    // control write addressed here
    input  logic [15:0]           i_ctrl_data,
    output logic [1:0]            o_valid,
    output logic [1:0][LEN_W-1:0] o_len,
    output logic                  o_usb_ptr,
    output logic                  o_cpu_ptr,
    output logic                  o_toggle,
    output logic                  o_stall,
    output logic                  o_done,
    output logic                  o_was_setup,
    output logic                  o_irq_src
);
    logic [1:0]            r_valid;
    logic [1:0][LEN_W-1:0] r_len;
    logic                  r_usb_ptr, r_cpu_ptr, r_toggle, r_stall, r_done, r_was_setup;
    logic                  w_cancel, w_hit, w_unused_data;

    // A cancel in the same cycle discards the completing transaction entirely
    assign w_cancel      = i_ctrl_wr && i_ctrl_data[CTRL_CANCEL];
    assign w_hit         = i_usb_hit && !w_cancel;
    assign w_unused_data = ^i_ctrl_data;

    // Bank/toggle/stall state; later statements take precedence (cancel last)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_len       <= '0;
            r_usb_ptr   <= 1'b0;
            r_cpu_ptr   <= 1'b0;
            r_toggle    <= 1'b0;
            r_stall     <= 1'b0;
            r_was_setup <= 1'b0;
        end else begin
            if (w_hit) begin
                r_valid[r_usb_ptr] <= 1'b0;
                r_usb_ptr          <= ~r_usb_ptr;
                r_toggle           <= ~r_toggle;
                if (!IS_IN) begin
                    r_len[r_usb_ptr] <= i_cnt;
                    r_was_setup      <= i_setup;
                end
            end
            if (i_setup_hit) begin
                r_toggle <= 1'b1;
                r_stall  <= 1'b0;
                if (IS_IN) begin
                    r_valid   <= '0;
                    r_usb_ptr <= 1'b0;
                    r_cpu_ptr <= 1'b0;
                end
            end
            if (i_ctrl_wr) begin
                // Commit lands on cpu_ptr, which is never the bank USB is draining
                if (i_ctrl_data[CTRL_COMMIT] && !r_valid[r_cpu_ptr]) begin
                    r_valid[r_cpu_ptr] <= 1'b1;
                    r_cpu_ptr          <= ~r_cpu_ptr;
                    if (IS_IN)
                        r_len[r_cpu_ptr] <= i_ctrl_data[LEN_W-1:0];
                end
                if (i_ctrl_data[CTRL_SET_STALL])
                    r_stall <= 1'b1;
                else if (i_ctrl_data[CTRL_CLR_STALL])
                    r_stall <= 1'b0;
                if (i_ctrl_data[CTRL_RST_TOGGLE])
                    r_toggle <= 1'b0;
                if (w_cancel) begin
                    r_valid   <= '0;
                    r_usb_ptr <= 1'b0;
                    r_cpu_ptr <= 1'b0;
                end
            end
        end
    end

    // Sticky completion flag; a new completion beats a CPU clear
    always_ff @(posedge clk) begin
        if (rst)
            r_done <= 1'b0;
        else if (w_hit)
            r_done <= 1'b1;
        else if (i_ctrl_wr && i_ctrl_data[CTRL_CLR_DONE])
            r_done <= 1'b0;
    end

`ifdef USB_EP_IRQ_MASK_EN
    logic r_mask;

    // Interrupt enable, rewritten by every control write to this ep/dir
    always_ff @(posedge clk) begin
        if (rst)
            r_mask <= 1'b0;
        else if (i_ctrl_wr)
            r_mask <= i_ctrl_data[CTRL_IRQ_EN];
    end

    assign o_irq_src = r_done && r_mask;
`else
    assign o_irq_src = r_done;
`endif

    assign o_valid     = r_valid;
    assign o_len       = r_len;
    assign o_usb_ptr   = r_usb_ptr;
    assign o_cpu_ptr   = r_cpu_ptr;
    assign o_toggle    = r_toggle;
    assign o_stall     = r_stall;
    assign o_done      = r_done;
    assign o_was_setup = r_was_setup;
endmodule

// File: rtl/usb_ep_array.sv
// usb_ep_array: EP_COUNT double-buffered bidirectional endpoints, the
// zero-latency endpoint mux toward the protocol engine, the CPU status
// register and the completion interrupt.
// Optional macro USB_EP_IRQ_MASK_EN: per ep/dir interrupt enable.
module usb_ep_array
    import usb_pkg::*;
#(
    parameter int EP_COUNT = 2,
    parameter int LEN_W    = 7
) (
    input logic           clk,
    input logic           rst,
    usb_ep_array_if.slave bus
);
    localparam int N = 2 * EP_COUNT;   // slice index = 2*ep + direction_in

    logic [N-1:0][1:0]            w_valid;
    logic [N-1:0][1:0][LEN_W-1:0] w_len;
    logic [N-1:0]                 w_usb_ptr, w_cpu_ptr, w_toggle, w_stall;
    logic [N-1:0]                 w_done, w_was_setup, w_irq_src;
    logic [EP_COUNT-1:0]          w_setup_hit;
    logic                         w_hit, w_s_vld, w_s_ptr, w_s_tog, w_s_stall;
    logic [LEN_W-1:0]             w_s_len;
    logic [15:0]                  w_stat, r_rd_data;
    logic                         r_irq;

    for (genvar e = 0; e < EP_COUNT; e++) begin : g_ep
        assign w_setup_hit[e] = bus.success && bus.setup && (bus.endpoint == 4'(e));
        for (genvar d = 0; d < 2; d++) begin : g_dir
            localparam int I = 2 * e + d;
            usb_ep_dir #(.IS_IN(d == 1), .LEN_W(LEN_W)) u_dir (
                .clk         (clk),
                .rst         (rst),
                .i_usb_hit   (bus.success && (bus.endpoint == 4'(e)) && (bus.direction_in == 1'(d))),
                .i_setup     (bus.setup),
                .i_setup_hit (w_setup_hit[e]),
                .i_cnt       (bus.cnt),
                .i_ctrl_wr   (bus.ctrl_wr_strobe && (bus.ctrl_ep == 4'(e)) && (bus.ctrl_dir_in == 1'(d))),
                .i_ctrl_data (bus.ctrl_wr_data),
                .o_valid     (w_valid[I]),
                .o_len       (w_len[I]),
                .o_usb_ptr   (w_usb_ptr[I]),
                .o_cpu_ptr   (w_cpu_ptr[I]),
                .o_toggle    (w_toggle[I]),
                .o_stall     (w_stall[I]),
                .o_done      (w_done[I]),
                .o_was_setup (w_was_setup[I]),
                .o_irq_src   (w_irq_src[I])
            );
        end
    end

    // Select the slice addressed by the protocol engine; no hit means ep >= EP_COUNT
    always_comb begin
        w_hit = 1'b0; w_s_vld = 1'b0; w_s_len = '0;
        w_s_ptr = 1'b0; w_s_tog = 1'b0; w_s_stall = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ({bus.endpoint, bus.direction_in} == 5'(i)) begin
                w_hit     = 1'b1;
                w_s_ptr   = w_usb_ptr[i];
                w_s_vld   = w_valid[i][w_usb_ptr[i]];
                w_s_len   = w_len[i][w_usb_ptr[i]];
                w_s_tog   = w_toggle[i];
                w_s_stall = w_stall[i];
            end
        end
    end

    // USB-side outputs, combinational; forced to idle/stall while in reset
    always_comb begin
        bus.handshake     = hs_stall;
        bus.toggle        = 1'b0;
        bus.bank          = 1'b0;
        bus.in_data_valid = 1'b0;
        if (!rst && w_hit) begin
            bus.toggle        = w_s_tog;
            bus.bank          = w_s_ptr;
            bus.in_data_valid = bus.direction_in && w_s_vld && (bus.cnt < w_s_len);
            if (w_s_stall)    bus.handshake = hs_stall;
            else if (w_s_vld) bus.handshake = hs_ack;
            else              bus.handshake = hs_nak;
        end
    end

    // Status word of the CPU-selected slice; unimplemented endpoints read 0
    always_comb begin
        w_stat = '0;
        for (int i = 0; i < N; i++) begin
            if ({bus.ctrl_ep, bus.ctrl_dir_in} == 5'(i)) begin
                w_stat[LEN_W-1:0]     = w_len[i][w_cpu_ptr[i]];
                w_stat[STAT_VALID_CUR] = w_valid[i][w_cpu_ptr[i]];
                w_stat[STAT_VALID_OTH] = w_valid[i][~w_cpu_ptr[i]];
                w_stat[STAT_STALL]     = w_stall[i];
                w_stat[STAT_TOGGLE]    = w_toggle[i];
                w_stat[STAT_CPU_PTR]   = w_cpu_ptr[i];
                w_stat[STAT_WAS_SETUP] = w_was_setup[i];
                w_stat[STAT_DONE]      = w_done[i];
            end
        end
    end

    // Register the status word and the interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_rd_data <= w_stat;
            r_irq     <= |w_irq_src;
        end
    end

    assign bus.ctrl_rd_data = r_rd_data;
    assign bus.irq          = r_irq;
endmodule

// File: tb/tb_usb_ep_array.sv
// Self-checking bench for usb_ep_array (EP_COUNT=2, LEN_W=7).
module tb_usb_ep_array;
    localparam logic [15:0] COMMIT   = 16'h0100;
    localparam logic [15:0] SET_ST   = 16'h0200;
    localparam logic [15:0] CLR_ST   = 16'h0400;
    localparam logic [15:0] CANCEL   = 16'h1000;
    localparam logic [15:0] CLR_DONE = 16'h2000;
    localparam logic [15:0] IRQ_EN   = 16'h4000;
    localparam logic [1:0]  ACK = 2'd0, NAK = 2'd2, STALL = 2'd3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    always #5 clk = ~clk;

    usb_ep_array_if #(.LEN_W(7)) bus ();
    usb_ep_array #(.EP_COUNT(2), .LEN_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick; @(posedge clk); #1; endtask

    task automatic wr(input logic [3:0] ep, input logic d, input logic [15:0] data);
        bus.ctrl_ep = ep; bus.ctrl_dir_in = d; bus.ctrl_wr_data = data;
        bus.ctrl_wr_strobe = 1'b1; tick; bus.ctrl_wr_strobe = 1'b0;
    endtask

    task automatic usb_sel(input logic [3:0] ep, input logic d, input logic [6:0] c);
        bus.endpoint = ep; bus.direction_in = d; bus.cnt = c; #1;
    endtask

    task automatic succ(input logic [3:0] ep, input logic d, input logic s, input logic [6:0] c);
        usb_sel(ep, d, c); bus.setup = s; bus.success = 1'b1;
        tick; bus.success = 1'b0; bus.setup = 1'b0;
    endtask

    // success and a control write to the same ep/dir in one cycle
    task automatic wr_succ(input logic [3:0] ep, input logic d, input logic [15:0] data, input logic [6:0] c);
        usb_sel(ep, d, c); bus.success = 1'b1;
        bus.ctrl_ep = ep; bus.ctrl_dir_in = d; bus.ctrl_wr_data = data; bus.ctrl_wr_strobe = 1'b1;
        tick; bus.success = 1'b0; bus.ctrl_wr_strobe = 1'b0;
    endtask

    task automatic rd(input logic [3:0] ep, input logic d);
        bus.ctrl_ep = ep; bus.ctrl_dir_in = d; tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.endpoint = 0; bus.direction_in = 0; bus.setup = 0; bus.success = 0; bus.cnt = 0;
        bus.ctrl_ep = 0; bus.ctrl_dir_in = 0; bus.ctrl_wr_strobe = 0; bus.ctrl_wr_data = 0;
        tick; tick;
        checks++; if (bus.handshake !== STALL) begin errors++; $display("FAIL rst_hs: got %0d want %0d", bus.handshake, STALL); end
        checks++; if (bus.toggle !== 1'b0) begin errors++; $display("FAIL rst_toggle: got %b want 0", bus.toggle); end
        checks++; if (bus.bank !== 1'b0) begin errors++; $display("FAIL rst_bank: got %b want 0", bus.bank); end
        checks++; if (bus.in_data_valid !== 1'b0) begin errors++; $display("FAIL rst_idv: got %b want 0", bus.in_data_valid); end
        checks++; if (bus.ctrl_rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd: got %h want 0", bus.ctrl_rd_data); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", bus.irq); end
        rst = 1'b0; tick;
    endtask

    task automatic test_out_basic;
        usb_sel(0, 0, 0);
        checks++; if (bus.handshake !== NAK) begin errors++; $display("FAIL out_idle_hs: got %0d want %0d", bus.handshake, NAK); end
        wr(0, 0, COMMIT);
        checks++; if (bus.handshake !== ACK) begin errors++; $display("FAIL out_commit_hs: got %0d want %0d", bus.handshake, ACK); end
        checks++; if (bus.bank !== 1'b0) begin errors++; $display("FAIL out_commit_bank: got %b want 0", bus.bank); end
        succ(0, 0, 0, 7'd8);
        // done=1, cpu_ptr=1, toggle=1, both valid bits 0
        exp_q.push_back(16'h9800); rd(0, 0); e = exp_q.pop_front();
        checks++; if (bus.ctrl_rd_data[15:8] !== e[15:8]) begin errors++; $display("FAIL out_done_stat: got %h want %h", bus.ctrl_rd_data[15:8], e[15:8]); end
        // commit bank 1: cpu_ptr back to 0, so the status shows len[0]=8
        wr(0, 0, COMMIT);
        exp_q.push_back(16'h8A08); rd(0, 0); e = exp_q.pop_front();
        checks++; if (bus.ctrl_rd_data !== e) begin errors++; $display("FAIL out_len_stat: got %h want %h", bus.ctrl_rd_data, e); end
    endtask

    task automatic test_in_zlp;
        wr(1, 1, COMMIT | 16'd5);
        wr(1, 1, COMMIT);
        usb_sel(1, 1, 0);
        checks++; if (bus.handshake !== ACK) begin errors++; $display("FAIL in_hs: got %0d want %0d", bus.handshake, ACK); end
        checks++; if (bus.bank !== 1'b0) begin errors++; $display("FAIL in_bank0: got %b want 0", bus.bank); end
        for (int c = 0; c <= 5; c++) begin
            usb_sel(1, 1, 7'(c));
            checks++;
            if (bus.in_data_valid !== (c < 5)) begin errors++; $display("FAIL in_idv cnt=%0d: got %b want %b", c, bus.in_data_valid, (c < 5)); end
        end
        succ(1, 1, 0, 7'd5);
        usb_sel(1, 1, 0);
        checks++; if (bus.bank !== 1'b1) begin errors++; $display("FAIL zlp_bank: got %b want 1", bus.bank); end
        checks++; if (bus.in_data_valid !== 1'b0) begin errors++; $display("FAIL zlp_idv: got %b want 0", bus.in_data_valid); end
        checks++; if (bus.handshake !== ACK) begin errors++; $display("FAIL zlp_hs: got %0d want %0d", bus.handshake, ACK); end
        succ(1, 1, 0, 7'd0);
        checks++; if (bus.handshake !== NAK) begin errors++; $display("FAIL zlp_done_hs: got %0d want %0d", bus.handshake, NAK); end
    endtask

    task automatic test_stall;
        wr(1, 0, COMMIT);
        usb_sel(1, 0, 0);
        wr(1, 0, SET_ST);
        checks++; if (bus.handshake !== STALL) begin errors++; $display("FAIL stall_set: got %0d want %0d", bus.handshake, STALL); end
        wr(1, 0, CLR_ST);
        checks++; if (bus.handshake !== ACK) begin errors++; $display("FAIL stall_clr: got %0d want %0d", bus.handshake, ACK); end
        wr(1, 0, SET_ST | CLR_ST);
        checks++; if (bus.handshake !== STALL) begin errors++; $display("FAIL stall_both: got %0d want %0d", bus.handshake, STALL); end
        wr(1, 0, CLR_ST);
        checks++; if (bus.handshake !== ACK) begin errors++; $display("FAIL stall_reclr: got %0d want %0d", bus.handshake, ACK); end
    endtask

    task automatic test_setup;
        wr(0, 1, COMMIT | 16'd3);
        wr(0, 1, SET_ST);
        usb_sel(0, 1, 0);
        checks++; if (bus.handshake !== STALL) begin errors++; $display("FAIL setup_pre_hs: got %0d want %0d", bus.handshake, STALL); end
        succ(0, 0, 1, 7'd8);
        // ep0 IN: stall, valid and pointers cleared, toggle=1, len[0]=3 kept
        exp_q.push_back(16'h0803); rd(0, 1); e = exp_q.pop_front();
        checks++; if (bus.ctrl_rd_data !== e) begin errors++; $display("FAIL setup_in_stat: got %h want %h", bus.ctrl_rd_data, e); end
        // ep0 OUT: toggle=1, was_setup=1, done=1, both banks free
        exp_q.push_back(16'hA808); rd(0, 0); e = exp_q.pop_front();
        checks++; if (bus.ctrl_rd_data !== e) begin errors++; $display("FAIL setup_out_stat: got %h want %h", bus.ctrl_rd_data, e); end
    endtask

    task automatic test_full_cancel;
        wr(0, 0, COMMIT); wr(0, 0, COMMIT); wr(0, 0, COMMIT);
        exp_q.push_back(16'hAB08); rd(0, 0); e = exp_q.pop_front();
        checks++; if (bus.ctrl_rd_data !== e) begin errors++; $display("FAIL full_stat: got %h want %h", bus.ctrl_rd_data, e); end
        wr(0, 0, CLR_DONE);
        wr_succ(0, 0, CANCEL, 7'd20);
        exp_q.push_back(16'h2808); rd(0, 0); e = exp_q.pop_front();
        checks++; if (bus.ctrl_rd_data !== e) begin errors++; $display("FAIL cancel_stat: got %h want %h", bus.ctrl_rd_data, e); end
        usb_sel(0, 0, 0);
        checks++; if (bus.handshake !== NAK) begin errors++; $display("FAIL cancel_hs: got %0d want %0d", bus.handshake, NAK); end
    endtask

    task automatic test_irq;
        logic exp_pre;
`ifdef USB_EP_IRQ_MASK_EN
        exp_pre = 1'b0;
`else
        exp_pre = 1'b1;
`endif
        checks++; if (bus.irq !== exp_pre) begin errors++; $display("FAIL irq_pre: got %b want %b", bus.irq, exp_pre); end
        wr(1, 1, CLR_DONE); tick;
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b want 0", bus.irq); end
        succ(1, 0, 0, 7'd4); tick;
        checks++; if (bus.irq !== exp_pre) begin errors++; $display("FAIL irq_done: got %b want %b", bus.irq, exp_pre); end
        wr(1, 0, IRQ_EN | COMMIT); tick;
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_enabled: got %b want 1", bus.irq); end
        wr_succ(1, 0, CLR_DONE | IRQ_EN, 7'd6); tick;
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_clr_vs_succ: got %b want 1", bus.irq); end
        exp_q.push_back(16'h8004); rd(1, 0); e = exp_q.pop_front();
        checks++; if (bus.ctrl_rd_data !== e) begin errors++; $display("FAIL irq_stat: got %h want %h", bus.ctrl_rd_data, e); end
    endtask

    task automatic test_bad_ep;
        usb_sel(3, 1, 0);
        checks++; if (bus.handshake !== STALL) begin errors++; $display("FAIL bad_hs: got %0d want %0d", bus.handshake, STALL); end
        checks++; if (bus.toggle !== 1'b0) begin errors++; $display("FAIL bad_toggle: got %b want 0", bus.toggle); end
        checks++; if (bus.bank !== 1'b0) begin errors++; $display("FAIL bad_bank: got %b want 0", bus.bank); end
        checks++; if (bus.in_data_valid !== 1'b0) begin errors++; $display("FAIL bad_idv: got %b want 0", bus.in_data_valid); end
        wr(3, 0, COMMIT | SET_ST); wr(3, 1, COMMIT | SET_ST | 16'd9);
        exp_q.push_back(16'h0000); rd(3, 0); e = exp_q.pop_front();
        checks++; if (bus.ctrl_rd_data !== e) begin errors++; $display("FAIL bad_rd: got %h want %h", bus.ctrl_rd_data, e); end
        exp_q.push_back(16'h8004); rd(1, 0); e = exp_q.pop_front();
        checks++; if (bus.ctrl_rd_data !== e) begin errors++; $display("FAIL bad_no_alias: got %h want %h", bus.ctrl_rd_data, e); end
        usb_sel(1, 0, 0);
        checks++; if (bus.handshake !== NAK) begin errors++; $display("FAIL bad_ep1_hs: got %0d want %0d", bus.handshake, NAK); end
    endtask

    initial begin
        test_reset;
        test_out_basic;
        test_in_zlp;
        test_stall;
        test_setup;
        test_full_cancel;
        test_irq;
        test_bad_ep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
